// File: rtl/uart_pkg.sv
// Shared UART definitions: framing constants, receiver states and the parity helper.
// Used by both the transmit and receive sides.
package uart_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int DEFAULT_DATA_BIT = 8;
  // start + data + parity + stop
  localparam int FRAME_BITS       = DEFAULT_DATA_BIT + 3;

  // Widest data word the parity helper accepts; callers zero-extend.
  localparam int MAX_DATA_BIT = 32;

  // Smallest usable bit period minus one; gives a distinct mid-bit sample point.
  localparam logic [15:0] MIN_DIV = 16'd3;

  typedef enum logic [2:0] {
    idleState,
    startState,
    dataState,
    parityState,
    stopState,
    breakState
  } rxStateType;

  function automatic logic evenParity(input logic [MAX_DATA_BIT-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin plus a falling-edge pulse.
// All stages reset to 1 so a line that idles high never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_sync,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta    <= 1'b1;
      rx_sync <= 1'b1;
      prev    <= 1'b1;
    end else begin
      // NOTE: non-blocking, so each stage captures the previous stage's old value and the chain is really three flops.
      meta    <= rx;
      rx_sync <= meta;
      prev    <= rx_sync;
    end
  end

  assign fall = prev & ~rx_sync;

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receiver (start, LSB-first data, even parity, stop) with a shift-history of good bytes.
// The newest byte is at rxMemory[0] and is also mirrored on the LEDs.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DATA_BIT   = 8,
  parameter int ITEM_COUNT = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [15:0]                         clkdiv,
  input  logic                                rx,
  input  logic                                clear,
  output logic [DATA_BIT-1:0]                 rxData,
  output logic                                valid,
  output logic                                parityError,
  output logic                                frameError,
  output logic                                overflow,
  output logic [DATA_BIT-1:0]                 led,
  output logic [$clog2(ITEM_COUNT+1)-1:0]     itemCount,
  output logic [ITEM_COUNT-1:0][DATA_BIT-1:0] rxMemory
);

  localparam int CW = $clog2(ITEM_COUNT + 1);
  localparam int BW = $clog2(DATA_BIT + 1);

  localparam logic [CW-1:0] FULL_COUNT = CW'(ITEM_COUNT);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BIT - 1);

  logic rx_s;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .rx_sync (rx_s),
    .fall    (rx_fall)
  );

  rxStateType state, state_next;

  logic [15:0]         cntr, cntr_next;
  logic [15:0]         eff_div;
  logic [15:0]         half_div;
  logic                bit_end;
  logic [BW-1:0]       bitcntr, bitcntr_next;
  logic [DATA_BIT-1:0] shift_q;
  logic                parity_q;

  logic shift_en;
  logic parity_en;
  logic commit;
  logic parity_evt;
  logic frame_evt;

  logic [CW-1:0] count_base;

  assign eff_div  = (clkdiv < MIN_DIV) ? MIN_DIV : clkdiv;
  assign half_div = eff_div >> 1;
  assign bit_end  = (cntr == eff_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= idleState;
      cntr    <= '0;
      bitcntr <= '0;
    end else begin
      state   <= state_next;
      cntr    <= cntr_next;
      bitcntr <= bitcntr_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch can leave one unassigned and infer a latch.
    state_next   = state;
    cntr_next    = cntr + 16'd1;
    bitcntr_next = bitcntr;
    shift_en     = 1'b0;
    parity_en    = 1'b0;
    commit       = 1'b0;
    parity_evt   = 1'b0;
    frame_evt    = 1'b0;

    case (state)
      idleState: begin
        cntr_next = '0;
        if (rx_fall) state_next = startState;
      end

      startState: begin
        // Mid-start-bit recheck rejects short glitches on the line.
        if (cntr == half_div) begin
          cntr_next    = '0;
          bitcntr_next = '0;
          state_next   = (rx_s == START_BIT) ? dataState : idleState;
        end
      end

      dataState: begin
        if (bit_end) begin
          cntr_next    = '0;
          shift_en     = 1'b1;
          bitcntr_next = bitcntr + 1'b1;
          if (bitcntr == LAST_BIT) state_next = parityState;
        end
      end

      parityState: begin
        if (bit_end) begin
          cntr_next  = '0;
          parity_en  = 1'b1;
          state_next = stopState;
        end
      end

      stopState: begin
        if (bit_end) begin
          cntr_next = '0;
          if (rx_s != STOP_BIT) begin
            frame_evt  = 1'b1;
            state_next = breakState;
          end else if (evenParity(MAX_DATA_BIT'(shift_q)) != parity_q) begin
            parity_evt = 1'b1;
            state_next = idleState;
          end else begin
            commit     = 1'b1;
            state_next = idleState;
          end
        end
      end

      breakState: begin
        // A held-low line must return high before a new start is accepted.
        cntr_next = '0;
        if (rx_s == STOP_BIT) state_next = idleState;
      end

      default: begin
        cntr_next  = '0;
        state_next = idleState;
      end
    endcase
  end

  // A clear coinciding with a commit is applied first, so the commit builds on an empty history.
  assign count_base = clear ? '0 : itemCount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the history is reset like any register because it drives output ports directly.
      shift_q     <= '0;
      parity_q    <= 1'b0;
      rxData      <= '0;
      led         <= '0;
      valid       <= 1'b0;
      parityError <= 1'b0;
      frameError  <= 1'b0;
      overflow    <= 1'b0;
      itemCount   <= '0;
      rxMemory    <= '0;
    end else begin
      valid <= commit;

      if (shift_en)  shift_q  <= {rx_s, shift_q[DATA_BIT-1:1]};
      if (parity_en) parity_q <= rx_s;

      parityError <= (parityError & ~clear) | parity_evt;
      frameError  <= (frameError  & ~clear) | frame_evt;
      overflow    <= (overflow    & ~clear) | (commit & (count_base == FULL_COUNT));

      if (commit) begin
        rxData      <= shift_q;
        led         <= shift_q;
        rxMemory[0] <= shift_q;
        for (int i = 1; i < ITEM_COUNT; i++) begin
          rxMemory[i] <= clear ? '0 : rxMemory[i-1];
        end
        itemCount <= (count_base == FULL_COUNT) ? FULL_COUNT : count_base + 1'b1;
      end else if (clear) begin
        rxMemory  <= '0;
        itemCount <= '0;
      end
    end
  end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
- UART receiver matching the team's 11-bit transmit frame: start=0, DATA_BIT data bits LSB first, even parity bit (XOR of data bits), stop=1.
- Bit period is clkdiv+1 clk cycles, same clkdiv convention as the transmit side.
- Good frames go into an ITEM_COUNT-deep history shift memory, newest at index 0, and are shown on the LEDs.
- Sits between the board RX pin and the user/LED logic.

Parameters:
- DATA_BIT, 8, data bits per frame.
- ITEM_COUNT, 4, depth of the received-byte history memory.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- clkdiv  input  16  bit period minus one, in clk cycles.
- rx  input  1  serial line, asynchronous to clk, idles high.
- clear  input  1  synchronous one-cycle request to clear the memory, count and sticky flags.
- rxData  output  DATA_BIT  last good byte.
- valid  output  1  one-cycle pulse on each good frame.
- parityError  output  1  sticky; set when a received parity bit mismatches.
- frameError  output  1  sticky; set when the stop bit is sampled 0.
- overflow  output  1  sticky; set when a good frame arrives while itemCount==ITEM_COUNT.
- led  output  DATA_BIT  mirrors rxData.
- itemCount  output  $clog2(ITEM_COUNT+1)  number of stored entries, saturating.
- rxMemory  output  [ITEM_COUNT-1:0][DATA_BIT-1:0]  history, [0] newest.

Behaviour:
- Reset (async, active-high) forces these values:
  - all outputs 0;
  - synchronizer flops to 1;
  - state idleState;
  - counters 0.
- Reset mid-frame aborts the frame and discards partial data; nothing is committed.
- rx passes through a 2-flop synchronizer. Falling-edge detect compares the synchronized value with its previous value.
- effDiv = max(clkdiv, 3). clkdiv values 0..2 are clamped to 3.
- cntr counts 0..effDiv; bitcntr counts data bits.
- States:
  - idleState: on a synchronized falling edge, set cntr=0 and go to startState.
  - startState: at cntr==effDiv>>1, sample the line.
    - If 0: cntr=0, bitcntr=0, go to dataState.
    - If 1: glitch; return to idleState with no flags and no pulse.
  - dataState: at each cntr==effDiv, shift the sample in LSB first and clear cntr. After DATA_BIT samples, go to parityState.
  - parityState: at cntr==effDiv, capture the parity bit and go to stopState.
  - stopState: at cntr==effDiv, evaluate the frame and return to idleState:
    - Stop==0: set frameError, go to breakState. Data is not stored.
    - Stop==1, parity mismatch: set parityError. Data is not stored.
    - Stop==1, parity correct: commit the frame.
  - breakState: wait until the synchronized rx is 1, then go to idleState. Prevents false starts during a held-low break.
- Commit, all updated on the same clock edge:
  - rxData and led take the new byte; valid=1 for exactly one cycle.
  - Memory shifts: [i]<=[i-1], [0]<=new byte.
  - itemCount increments, saturating at ITEM_COUNT.
  - If the count was already ITEM_COUNT, the oldest entry drops and overflow is set.
- Latency: from the synchronized falling edge to valid is (effDiv>>1)+1 + (DATA_BIT+2)*(effDiv+1) cycles. The synchronizer adds 2 more cycles relative to the pin.
- clear:
  - Zeroes rxMemory, itemCount, parityError, frameError and overflow.
  - Does not touch rxData, led, or a reception in progress.
- clear in the same cycle as a commit or error detection: clear applies first, then the event. Result: memory[0]=new byte with the others 0 and itemCount=1, or only the new error flag set.
- Sticky flags stay set until clear or reset.

Decomposition:
- Package uart_pkg holds:
  - START_BIT=1'b0, STOP_BIT=1'b1;
  - FRAME_BITS=DATA_BIT+3;
  - enum rxStateType {idleState, startState, dataState, parityState, stopState, breakState};
  - function evenParity(data).
- One sub-module, uart_rx_sync: 2-flop synchronizer plus falling-edge pulse, reset value 1.

Test Plan (clkdiv=15, i.e. 16 cycles per bit):
- Frame 0xA5 with parity 0 and stop 1 -> valid pulses exactly once; rxData=led=0xA5; rxMemory[0]=0xA5; itemCount=1; all flags 0.
- Frame 0x01 with parity bit 0 (wrong) -> parityError=1; no valid pulse; itemCount and memory unchanged.
- Frame 0x3C with stop=0, rx held low 3 bit periods, then idle, then a good 0x3C -> frameError=1 with no spurious frame during the low period; the second frame commits with rxMemory[0]=0x3C.
- rx low for 4 cycles then high -> no valid, no flags; the next good frame 0x5A is received correctly.
- Good frames 0x11,0x22,0x33,0x44,0x55 -> rxMemory = {[0]=0x55,[1]=0x44,[2]=0x33,[3]=0x22}, itemCount=4, overflow=1. Then pulse clear -> memory, count and flags all 0; rxData stays 0x55.
- reset asserted during data bit 4 of a frame -> outputs 0 immediately, asynchronously. Release, then a good frame 0x7E -> received with itemCount=1.
